scu_param: RTL and testbench

Parametrised multicycle processor core: a bank of `NREGS` general registers of `DATA_W` bits, an accumulator A, a result register G, a shared bus and a control FSM that executes one instruction per `Run` request. It is the next generation of the simple control unit and datapath. It generalises width and register count, adds logical-AND and conditional-move instructions, and adds a `Busy` status output. It sits between the instruction/data source driving `Din` and any bus observer.

---
 rtl/scu_pkg.sv | 33 +++
 rtl/scu_ctrl.sv | 115 +++++++++++
 rtl/scu_param.sv | 99 +++++++++
 tb/tb_scu_param.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scu_pkg.sv
// Shared definitions for the parametrised control unit: opcodes, FSM states,
// ALU operation codes and the layout of the one-hot bus select.
package scu_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_MVNZ = 3'b101;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } scu_state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2
  } alu_op_t;

  // Bus select is NREGS+2 bits wide: bits [NREGS-1:0] pick Rn, then G, then Din.
  localparam int SEL_G_OFS   = 0;
  localparam int SEL_DIN_OFS = 1;

  function automatic int bus_sel_w(input int nregs);
    return nregs + 2;
  endfunction

endpackage

// File: rtl/scu_ctrl.sv
// Control FSM: sequences T0..T3 and decodes IR into write enables, bus
// select, ALU operation and the Done/Busy status outputs.
//
// state | meaning
// T0    | idle, latch IR from Din when Run is high
// T1    | single-cycle ops complete here; arithmetic loads A from Rx
// T2    | G <= A op Ry
// T3    | Rx <= G, instruction complete
module scu_ctrl
  import scu_pkg::*;
#(
  parameter int NREGS  = 8,
  parameter int REG_AW = $clog2(NREGS),
  parameter int IR_W   = 3 + 2 * REG_AW
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  input  logic [IR_W-1:0]   ir,
  input  logic              g_nz,
  output logic              ir_in,
  output logic [NREGS-1:0]  r_in,
  output logic              a_in,
  output logic              g_in,
  output logic [NREGS+1:0]  bus_sel,
  output alu_op_t           alu_op,
  output logic              done,
  output logic              busy
);

  scu_state_t state_q, state_d;

  logic [2:0]        op;
  logic [REG_AW-1:0] x;
  logic [REG_AW-1:0] y;

  assign op = ir[IR_W-1 -: 3];
  assign x  = ir[2*REG_AW-1 -: REG_AW];
  assign y  = ir[REG_AW-1:0];

  // Next-state and control decode from current state and IR.
  always_comb begin
    state_d = state_q;
    ir_in   = 1'b0;
    r_in    = '0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    bus_sel = '0;
    alu_op  = ALU_ADD;
    done    = 1'b0;
    busy    = (state_q != T0);
    case (state_q)
      T0: begin
        if (run) begin
          ir_in   = 1'b1;
          state_d = T1;
        end
      end
      T1: begin
        case (op)
          OP_MV: begin
            bus_sel[y] = 1'b1;
            r_in[x]    = 1'b1;
            done       = 1'b1;
            state_d    = T0;
          end
          OP_MVI: begin
            bus_sel[NREGS+SEL_DIN_OFS] = 1'b1;
            r_in[x] = 1'b1;
            done    = 1'b1;
            state_d = T0;
          end
          OP_MVNZ: begin
            bus_sel[y] = 1'b1;
            r_in[x]    = g_nz;
            done       = 1'b1;
            state_d    = T0;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            bus_sel[x] = 1'b1;
            a_in       = 1'b1;
            state_d    = T2;
          end
          default: begin
            done    = 1'b1;
            state_d = T0;
          end
        endcase
      end
      T2: begin
        bus_sel[y] = 1'b1;
        g_in       = 1'b1;
        case (op)
          OP_SUB:  alu_op = ALU_SUB;
          OP_AND:  alu_op = ALU_AND;
          default: alu_op = ALU_ADD;
        endcase
        state_d = T3;
      end
      T3: begin
        bus_sel[NREGS+SEL_G_OFS] = 1'b1;
        r_in[x] = 1'b1;
        done    = 1'b1;
        state_d = T0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= T0;
    else         state_q <= state_d;
  end

endmodule

// File: rtl/scu_param.sv
// Parametrised multicycle core: register bank, accumulator A, result G,
// instruction register, ALU and the shared bus, sequenced by scu_ctrl.
module scu_param
  import scu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] Din,
  output logic              Done,
  output logic              Busy,
  output logic [DATA_W-1:0] Bus
);

  localparam int REG_AW = $clog2(NREGS);
  localparam int IR_W   = 3 + 2 * REG_AW;

  logic [DATA_W-1:0] r_q [NREGS];
  logic [DATA_W-1:0] r_d [NREGS];
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] g_q, g_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0] alu_y;

  logic              ir_in;
  logic [NREGS-1:0]  r_in;
  logic              a_in;
  logic              g_in;
  logic [NREGS+1:0]  bus_sel;
  alu_op_t           alu_op;

  scu_ctrl #(
    .NREGS  (NREGS),
    .REG_AW (REG_AW),
    .IR_W   (IR_W)
  ) u_ctrl (
    .clk     (clk),
    .resetn  (Resetn),
    .run     (Run),
    .ir      (ir_q),
    .g_nz    (|g_q),
    .ir_in   (ir_in),
    .r_in    (r_in),
    .a_in    (a_in),
    .g_in    (g_in),
    .bus_sel (bus_sel),
    .alu_op  (alu_op),
    .done    (Done),
    .busy    (Busy)
  );

  // One-hot bus mux; an empty select leaves the bus at zero.
  always_comb begin
    Bus = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (bus_sel[i]) Bus = Bus | r_q[i];
    end
    if (bus_sel[NREGS+SEL_G_OFS])   Bus = Bus | g_q;
    if (bus_sel[NREGS+SEL_DIN_OFS]) Bus = Bus | Din;
  end

  // ALU: A combined with the bus, wrapping modulo 2^DATA_W.
  always_comb begin
    case (alu_op)
      ALU_SUB: alu_y = a_q - Bus;
      ALU_AND: alu_y = a_q & Bus;
      default: alu_y = a_q + Bus;
    endcase
  end

  // Next values for all datapath registers from the controller enables.
  always_comb begin
    ir_d = ir_in ? Din[IR_W-1:0] : ir_q;
    a_d  = a_in ? Bus : a_q;
    g_d  = g_in ? alu_y : g_q;
    for (int i = 0; i < NREGS; i++) begin
      r_d[i] = r_in[i] ? Bus : r_q[i];
    end
  end

  // Datapath registers; reset wins over any write enabled in the same cycle.
  always_ff @(posedge clk) begin
    if (!Resetn) begin
      ir_q <= '0;
      a_q  <= '0;
      g_q  <= '0;
      for (int i = 0; i < NREGS; i++) r_q[i] <= '0;
    end else begin
      ir_q <= ir_d;
      a_q  <= a_d;
      g_q  <= g_d;
      for (int i = 0; i < NREGS; i++) r_q[i] <= r_d[i];
    end
  end

endmodule

// File: tb/tb_scu_param.sv
// Directed bench for scu_param at three parameter points (16/8, 8/4, 32/16).
module tb_scu_param;
  import scu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run16, run8, run32;
  logic [31:0] din;
  logic        done16, busy16, done8, busy8, done32, busy32;
  logic [15:0] bus16;
  logic [7:0]  bus8;
  logic [31:0] bus32;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  scu_param #(.DATA_W(16), .NREGS(8)) u_d16 (
    .clk(clk), .Resetn(rst_n), .Run(run16), .Din(din[15:0]),
    .Done(done16), .Busy(busy16), .Bus(bus16));

  scu_param #(.DATA_W(8), .NREGS(4)) u_d8 (
    .clk(clk), .Resetn(rst_n), .Run(run8), .Din(din[7:0]),
    .Done(done8), .Busy(busy8), .Bus(bus8));

  scu_param #(.DATA_W(32), .NREGS(16)) u_d32 (
    .clk(clk), .Resetn(rst_n), .Run(run32), .Din(din),
    .Done(done32), .Busy(busy32), .Bus(bus32));

  // w: 0 = 16-bit/8 regs, 1 = 8-bit/4 regs, 2 = 32-bit/16 regs
  function automatic logic [31:0] enc(input int w, input logic [2:0] op, input int x, input int y);
    int aw;
    aw = (w == 0) ? 3 : (w == 1) ? 2 : 4;
    return (32'(op) << (2 * aw)) | (32'(x) << aw) | 32'(y);
  endfunction

  function automatic logic g_done(input int w);
    return (w == 0) ? done16 : (w == 1) ? done8 : done32;
  endfunction

  function automatic logic [31:0] g_bus(input int w);
    return (w == 0) ? {16'h0, bus16} : (w == 1) ? {24'h0, bus8} : bus32;
  endfunction

  task automatic set_run(input int w, input logic v);
    if (w == 0) run16 = v;
    else if (w == 1) run8 = v;
    else run32 = v;
  endtask

  // Issue one instruction from T0 (called just after a rising edge). Returns the
  // cycle number of Done counted from the Run cycle (0 if it never came), the
  // bus in T1 and the bus in the Done cycle. Leaves the DUT in T0.
  task automatic exec(input int w, input logic [31:0] instr, input logic [31:0] imm,
                      output int ncyc, output logic [31:0] bus_t1, output logic [31:0] bus_last);
    logic got;
    got = 1'b0; ncyc = 0; bus_t1 = '0; bus_last = '0;
    set_run(w, 1'b1);
    din = instr;
    for (int k = 0; k < 8; k++) begin
      if (!got) begin
        @(posedge clk); #1;
        if (k == 0) begin
          set_run(w, 1'b0);
          din = imm;
        end
        @(negedge clk);
        if (k == 0) bus_t1 = g_bus(w);
        if (g_done(w)) begin
          ncyc = k + 2;
          bus_last = g_bus(w);
          got = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    din = '0;
  endtask

  task automatic read_reg(input int w, input int r, output logic [31:0] v);
    int n;
    logic [31:0] last;
    exec(w, enc(w, OP_MV, r, r), 32'h0, n, v, last);
  endtask

  task automatic test_reset();
    int bad;
    logic [31:0] v;
    rst_n = 1'b0; run16 = 1'b0; run8 = 1'b0; run32 = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    tests++; if (done16 !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done16); end
    tests++; if (busy16 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy16); end
    tests++; if (bus16 !== 16'h0) begin fails++; $display("FAIL reset_bus got %h want 0000", bus16); end
    tests++; if ({busy8, busy32} !== 2'b00) begin fails++; $display("FAIL reset_busy_sweep got %b want 00", {busy8, busy32}); end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy16 !== 1'b0 || done16 !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL idle_hold got %0d busy cycles want 0", bad); end
    @(posedge clk); #1;
    for (int r = 0; r < 8; r++) begin
      read_reg(0, r, v);
      tests++; if (v !== 32'h0) begin fails++; $display("FAIL reset_reg R%0d got %h want 0", r, v); end
    end
  endtask

  task automatic test_back_to_back();
    int n; logic [31:0] t1, last, v;
    exec(0, enc(0, OP_MVI, 0, 0), 32'd5, n, t1, last);
    tests++; if (n != 2) begin fails++; $display("FAIL mvi0_lat got %0d want 2", n); end
    tests++; if (t1 !== 32'd5) begin fails++; $display("FAIL mvi0_bus got %h want 5", t1); end
    exec(0, enc(0, OP_MVI, 1, 0), 32'd3, n, t1, last);
    tests++; if (n != 2) begin fails++; $display("FAIL mvi1_lat got %0d want 2", n); end
    read_reg(0, 0, v);
    tests++; if (v !== 32'd5) begin fails++; $display("FAIL b2b_R0 got %h want 5", v); end
    read_reg(0, 1, v);
    tests++; if (v !== 32'd3) begin fails++; $display("FAIL b2b_R1 got %h want 3", v); end
  endtask

  task automatic test_arith();
    int n; logic [31:0] t1, last, v;
    exec(0, enc(0, OP_ADD, 0, 1), 32'h0, n, t1, last);
    tests++; if (n != 4) begin fails++; $display("FAIL add_lat got %0d want 4", n); end
    tests++; if (t1 !== 32'd5) begin fails++; $display("FAIL add_t1_bus got %h want 5", t1); end
    tests++; if (last !== 32'd8) begin fails++; $display("FAIL add_t3_bus got %h want 8", last); end
    exec(0, enc(0, OP_SUB, 1, 0), 32'h0, n, t1, last);
    tests++; if (last !== 32'hFFFB) begin fails++; $display("FAIL sub_wrap got %h want fffb", last); end
    exec(0, enc(0, OP_AND, 0, 1), 32'h0, n, t1, last);
    tests++; if (n != 4) begin fails++; $display("FAIL and_lat got %0d want 4", n); end
    tests++; if (last !== 32'h0008) begin fails++; $display("FAIL and_res got %h want 0008", last); end
    read_reg(0, 1, v);
    tests++; if (v !== 32'hFFFB) begin fails++; $display("FAIL sub_R1 got %h want fffb", v); end
  endtask

  task automatic test_mvnz();
    int n; logic [31:0] t1, last, v;
    exec(0, enc(0, OP_MVI, 2, 0), 32'h1234, n, t1, last);
    exec(0, enc(0, OP_SUB, 3, 3), 32'h0, n, t1, last);
    tests++; if (last !== 32'h0) begin fails++; $display("FAIL sub_self got %h want 0", last); end
    exec(0, enc(0, OP_MVNZ, 2, 0), 32'h0, n, t1, last);
    tests++; if (n != 2) begin fails++; $display("FAIL mvnz_lat got %0d want 2", n); end
    read_reg(0, 2, v);
    tests++; if (v !== 32'h1234) begin fails++; $display("FAIL mvnz_gz got %h want 1234", v); end
    exec(0, enc(0, OP_ADD, 4, 0), 32'h0, n, t1, last);
    tests++; if (last !== 32'd8) begin fails++; $display("FAIL add_R4 got %h want 8", last); end
    exec(0, enc(0, OP_MVNZ, 2, 0), 32'h0, n, t1, last);
    read_reg(0, 2, v);
    tests++; if (v !== 32'd8) begin fails++; $display("FAIL mvnz_gnz got %h want 8", v); end
    exec(0, enc(0, OP_ADD, 2, 2), 32'h0, n, t1, last);
    tests++; if (last !== 32'd16) begin fails++; $display("FAIL add_self got %h want 10", last); end
  endtask

  task automatic test_noop();
    int n; logic [31:0] t1, last, v;
    exec(0, enc(0, 3'b111, 0, 1), 32'h0, n, t1, last);
    tests++; if (n != 2) begin fails++; $display("FAIL nop7_lat got %0d want 2", n); end
    tests++; if (t1 !== 32'h0) begin fails++; $display("FAIL nop7_bus got %h want 0", t1); end
    exec(0, enc(0, 3'b110, 1, 0), 32'h0, n, t1, last);
    tests++; if (n != 2) begin fails++; $display("FAIL nop6_lat got %0d want 2", n); end
    read_reg(0, 0, v);
    tests++; if (v !== 32'd8) begin fails++; $display("FAIL nop_R0 got %h want 8", v); end
    read_reg(0, 1, v);
    tests++; if (v !== 32'hFFFB) begin fails++; $display("FAIL nop_R1 got %h want fffb", v); end
  endtask

  task automatic test_run_ignore();
    int extra; logic d3; logic [31:0] v;
    run16 = 1'b1; din = enc(0, OP_ADD, 0, 0);
    @(posedge clk); #1 run16 = 1'b0;
    @(posedge clk); #1 run16 = 1'b1; din = enc(0, OP_MVI, 7, 0);
    @(posedge clk); #1 run16 = 1'b0; din = 32'h00AA;
    @(negedge clk); d3 = done16;
    tests++; if (d3 !== 1'b1) begin fails++; $display("FAIL ign_t3_done got %b want 1", d3); end
    extra = 0;
    repeat (4) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (done16 !== 1'b0 || busy16 !== 1'b0) extra++;
    end
    tests++; if (extra != 0) begin fails++; $display("FAIL ign_extra got %0d active cycles want 0", extra); end
    @(posedge clk); #1 din = '0;
    read_reg(0, 0, v);
    tests++; if (v !== 32'd16) begin fails++; $display("FAIL ign_R0 got %h want 10", v); end
    read_reg(0, 7, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL ign_R7 got %h want 0", v); end
  endtask

  task automatic test_abort();
    int n; logic [31:0] t1, last, v;
    exec(0, enc(0, OP_MVI, 5, 0), 32'd7, n, t1, last);
    run16 = 1'b1; din = enc(0, OP_ADD, 5, 5);
    @(posedge clk); #1 run16 = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    tests++; if (busy16 !== 1'b1) begin fails++; $display("FAIL abort_in_t2 got %b want 1", busy16); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    tests++; if ({done16, busy16} !== 2'b00) begin fails++; $display("FAIL abort_state got %b want 00", {done16, busy16}); end
    tests++; if (bus16 !== 16'h0) begin fails++; $display("FAIL abort_bus got %h want 0000", bus16); end
    @(posedge clk); #1;
    read_reg(0, 5, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL abort_R5 got %h want 0", v); end
    exec(0, enc(0, OP_MVI, 6, 0), 32'd9, n, t1, last);
    exec(0, enc(0, OP_MVNZ, 6, 5), 32'h0, n, t1, last);
    read_reg(0, 6, v);
    tests++; if (v !== 32'd9) begin fails++; $display("FAIL abort_g_clr got %h want 9", v); end
    rst_n = 1'b0; run16 = 1'b1; din = enc(0, OP_MVI, 0, 0);
    @(posedge clk); #1 rst_n = 1'b1; run16 = 1'b0;
    @(negedge clk);
    tests++; if (busy16 !== 1'b0) begin fails++; $display("FAIL rst_prio got %b want 0", busy16); end
    @(posedge clk); #1;
  endtask

  task automatic test_param_sweep();
    int n; logic [31:0] t1, last, v;
    exec(1, enc(1, OP_MVI, 3, 0), 32'hF0, n, t1, last);
    tests++; if (t1 !== 32'hF0) begin fails++; $display("FAIL w8_mvi got %h want f0", t1); end
    exec(1, enc(1, OP_MVI, 0, 0), 32'h20, n, t1, last);
    exec(1, enc(1, OP_ADD, 3, 0), 32'h0, n, t1, last);
    tests++; if (n != 4) begin fails++; $display("FAIL w8_add_lat got %0d want 4", n); end
    tests++; if (last !== 32'h10) begin fails++; $display("FAIL w8_add got %h want 10", last); end
    read_reg(1, 3, v);
    tests++; if (v !== 32'h10) begin fails++; $display("FAIL w8_R3 got %h want 10", v); end
    exec(1, enc(1, OP_MVI, 1, 0), 32'h05, n, t1, last);
    exec(1, enc(1, OP_SUB, 1, 3), 32'h0, n, t1, last);
    tests++; if (last !== 32'hF5) begin fails++; $display("FAIL w8_sub got %h want f5", last); end

    exec(2, enc(2, OP_MVI, 15, 0), 32'hFFFF_FFF0, n, t1, last);
    tests++; if (t1 !== 32'hFFFF_FFF0) begin fails++; $display("FAIL w32_mvi got %h want fffffff0", t1); end
    exec(2, enc(2, OP_MVI, 0, 0), 32'h20, n, t1, last);
    exec(2, enc(2, OP_ADD, 15, 0), 32'h0, n, t1, last);
    tests++; if (n != 4) begin fails++; $display("FAIL w32_add_lat got %0d want 4", n); end
    tests++; if (last !== 32'h10) begin fails++; $display("FAIL w32_add got %h want 10", last); end
    read_reg(2, 15, v);
    tests++; if (v !== 32'h10) begin fails++; $display("FAIL w32_R15 got %h want 10", v); end
    exec(2, enc(2, OP_MVI, 14, 0), 32'h8000_0001, n, t1, last);
    exec(2, enc(2, OP_MVI, 13, 0), 32'hF000_000F, n, t1, last);
    exec(2, enc(2, OP_AND, 14, 13), 32'h0, n, t1, last);
    tests++; if (last !== 32'h8000_0001) begin fails++; $display("FAIL w32_and got %h want 80000001", last); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_arith();
    test_mvnz();
    test_noop();
    test_run_ignore();
    test_abort();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
